// File: rtl/instruction_controller.sv
`default_nettype none
// ============================================================================
// Module      : instruction_controller
// Description : Multi-cycle control unit for a small register-bank processor.
//               Latches a 9-bit instruction (III XXX YYY) on a run request in
//               IDLE, then sequences T1..T3 and decodes the bank, ALU and bus
//               mux controls from the state and the latched instruction.
//               Optional feature: define INSTRUCTION_CONTROLLER_MVNZ_EN to
//               compile in opcode 100 (mvnz, move if R is non-zero).
// Ports       : clock     - rising-edge clock
//               reset_n   - synchronous active-low reset
//               run       - start request, sampled only in IDLE
//               ir_data   - instruction: opcode [8:6], rX [5:3], rY [2:0]
//               r_zero    - R holds zero (mvnz only)
//               enable    - one-hot register write-enable to the bank
//               enable_a  - load A from the bank output
//               enable_r  - load R from the ALU
//               reg_num   - bank read select (0 when no read is active)
//               sel_din   - bus mux selects immediate data input
//               sel_r     - bus mux selects R
//               alu_sub   - ALU subtracts when high, adds when low
//               done      - pulse in the final cycle of an instruction
//               busy      - state is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_controller (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       run,
    input  logic [8:0] ir_data,
    input  logic       r_zero,
    output logic [7:0] enable,
    output logic       enable_a,
    output logic       enable_r,
    output logic [2:0] reg_num,
    output logic       sel_din,
    output logic       sel_r,
    output logic       alu_sub,
    output logic       done,
    output logic       busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_t1   = 2'd1;
    localparam logic [1:0] c_st_t2   = 2'd2;
    localparam logic [1:0] c_st_t3   = 2'd3;

    localparam logic [2:0] c_op_mv   = 3'b000;
    localparam logic [2:0] c_op_mvi  = 3'b001;
    localparam logic [2:0] c_op_add  = 3'b010;
    localparam logic [2:0] c_op_sub  = 3'b011;
`ifdef INSTRUCTION_CONTROLLER_MVNZ_EN
    localparam logic [2:0] c_op_mvnz = 3'b100;
`endif

    logic [1:0] r_state;
    logic [8:0] r_instr;

    logic [2:0] w_op;
    logic [2:0] w_rx;
    logic [2:0] w_ry;
    logic [7:0] w_rx_onehot;
    logic       w_is_alu;

    assign w_op        = r_instr[8:6];
    assign w_rx        = r_instr[5:3];
    assign w_ry        = r_instr[2:0];
    assign w_rx_onehot = 8'd1 << w_rx;
    assign w_is_alu    = (w_op == c_op_add) || (w_op == c_op_sub);

`ifndef INSTRUCTION_CONTROLLER_MVNZ_EN
    // r_zero only matters for mvnz; keep it visibly consumed in this build.
    logic w_unused;
    assign w_unused = r_zero;
`endif

    // State and instruction register. The instruction is captured only on an
    // IDLE start so later changes on ir_data cannot disturb a running decode.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
            r_instr <= 9'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (run) begin
                        r_instr <= ir_data;
                        r_state <= c_st_t1;
                    end
                end
                c_st_t1: r_state <= w_is_alu ? c_st_t2 : c_st_idle;
                c_st_t2: r_state <= c_st_t3;
                c_st_t3: r_state <= c_st_idle;
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Output decode. Gating with reset_n keeps every output low for the whole
    // reset interval, including the cycle before the reset edge lands.
    always_comb begin
        enable   = 8'd0;
        enable_a = 1'b0;
        enable_r = 1'b0;
        reg_num  = 3'd0;
        sel_din  = 1'b0;
        sel_r    = 1'b0;
        alu_sub  = 1'b0;
        done     = 1'b0;
        busy     = 1'b0;
        if (reset_n) begin
            case (r_state)
                c_st_t1: begin
                    busy = 1'b1;
                    case (w_op)
                        c_op_mv: begin
                            reg_num = w_ry;
                            enable  = w_rx_onehot;
                            done    = 1'b1;
                        end
                        c_op_mvi: begin
                            sel_din = 1'b1;
                            enable  = w_rx_onehot;
                            done    = 1'b1;
                        end
                        c_op_add, c_op_sub: begin
                            reg_num  = w_rx;
                            enable_a = 1'b1;
                        end
`ifdef INSTRUCTION_CONTROLLER_MVNZ_EN
                        c_op_mvnz: begin
                            if (!r_zero) begin
                                reg_num = w_ry;
                                enable  = w_rx_onehot;
                            end
                            done = 1'b1;
                        end
`endif
                        default: done = 1'b1;
                    endcase
                end
                c_st_t2: begin
                    busy     = 1'b1;
                    reg_num  = w_ry;
                    enable_r = 1'b1;
                    alu_sub  = (w_op == c_op_sub);
                end
                c_st_t3: begin
                    busy   = 1'b1;
                    sel_r  = 1'b1;
                    enable = w_rx_onehot;
                    done   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_controller
// Description : Self-checking bench for instruction_controller. A reference
//               model tracks the latched instruction and its cycle position
//               and lists the expected controls per opcode; directed tasks
//               add fixed expected values, and a random task mixes starts,
//               run toggles, r_zero changes and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_controller;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       run;
    logic [8:0] ir_data;
    logic       r_zero;
    logic [7:0] enable;
    logic       enable_a, enable_r, sel_din, sel_r, alu_sub, done, busy;
    logic [2:0] reg_num;

    int n_total = 0;
    int n_pass  = 0;

    instruction_controller dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .run      (run),
        .ir_data  (ir_data),
        .r_zero   (r_zero),
        .enable   (enable),
        .enable_a (enable_a),
        .enable_r (enable_r),
        .reg_num  (reg_num),
        .sel_din  (sel_din),
        .sel_r    (sel_r),
        .alu_sub  (alu_sub),
        .done     (done),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    // {enable, enable_a, enable_r, reg_num, sel_din, sel_r, alu_sub, done, busy}
    logic [17:0] obs;
    assign obs = {enable, enable_a, enable_r, reg_num, sel_din, sel_r, alu_sub, done, busy};

    // ---------------- reference model ----------------
    logic [8:0] m_instr = 9'd0;
    int         m_step  = 0;     // 0 = idle, otherwise cycle number inside instruction

    function automatic int instr_len(input logic [8:0] ins);
        return (ins[8:6] == 3'b010 || ins[8:6] == 3'b011) ? 3 : 1;
    endfunction

    function automatic logic [17:0] pack(input logic [7:0] en, input logic ea, input logic er,
                                         input logic [2:0] rn, input logic sd, input logic sr,
                                         input logic as, input logic dn, input logic bz);
        return {en, ea, er, rn, sd, sr, as, dn, bz};
    endfunction

    function automatic logic [17:0] model_out();
        logic [2:0] op, rx, ry;
        logic [7:0] wr;
        op = m_instr[8:6];
        rx = m_instr[5:3];
        ry = m_instr[2:0];
        wr = 8'd0;
        wr[rx] = 1'b1;
        if (!reset_n || m_step == 0) return 18'd0;
        case (op)
            3'b000: return pack(wr, 0, 0, ry, 0, 0, 0, 1, 1);
            3'b001: return pack(wr, 0, 0, 3'd0, 1, 0, 0, 1, 1);
            3'b010, 3'b011: begin
                if (m_step == 1) return pack(8'd0, 1, 0, rx, 0, 0, 0, 0, 1);
                if (m_step == 2) return pack(8'd0, 0, 1, ry, 0, 0, op[0], 0, 1);
                return pack(wr, 0, 0, 3'd0, 0, 1, 0, 1, 1);
            end
`ifdef INSTRUCTION_CONTROLLER_MVNZ_EN
            3'b100: return r_zero ? pack(8'd0, 0, 0, 3'd0, 0, 0, 0, 1, 1)
                                  : pack(wr, 0, 0, ry, 0, 0, 0, 1, 1);
`endif
            default: return pack(8'd0, 0, 0, 3'd0, 0, 0, 0, 1, 1);
        endcase
    endfunction

    task automatic model_edge();
        if (!reset_n) begin
            m_step  = 0;
            m_instr = 9'd0;
        end else if (m_step == 0) begin
            if (run) begin
                m_instr = ir_data;
                m_step  = 1;
            end
        end else if (m_step == instr_len(m_instr)) begin
            m_step = 0;
        end else begin
            m_step = m_step + 1;
        end
    endtask

    // Advance one clock; outputs are settled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; run = 1'b1; ir_data = 9'b010_001_010; r_zero = 1'b0;
        #1;
        n_total++;
        if (obs !== 18'd0) $display("FAIL reset_pre obs=%h exp=%h", obs, 18'd0);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (obs !== 18'd0 || obs !== model_out())
                $display("FAIL reset_hold obs=%h exp=%h", obs, 18'd0);
            else n_pass++;
        end
        run = 1'b0;
        reset_n = 1'b1;
        tick();
        n_total++;
        if (busy !== 1'b0 || obs !== model_out()) $display("FAIL reset_release obs=%h exp=%h", obs, model_out());
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        ir_data = 9'b010_000_101; run = 1'b1;
        tick();                         // T1
        run = 1'b0;
        tick();                         // T2
        n_total++;
        if (enable_r !== 1'b1 || obs !== model_out()) $display("FAIL abort_t2 obs=%h exp=%h", obs, model_out());
        else n_pass++;
        reset_n = 1'b0;
        tick();
        n_total++;
        if (obs !== 18'd0) $display("FAIL abort_reset obs=%h exp=%h", obs, 18'd0);
        else n_pass++;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (obs !== 18'd0 || obs !== model_out()) $display("FAIL abort_after obs=%h exp=%h", obs, 18'd0);
            else n_pass++;
        end
    endtask

    task automatic test_mvi();
        ir_data = 9'b001_100_000; run = 1'b1;
        tick();
        run = 1'b0;
        n_total++;
        if (obs !== pack(8'b0001_0000, 0, 0, 3'd0, 1, 0, 0, 1, 1) || obs !== model_out())
            $display("FAIL mvi_t1 obs=%h exp=%h", obs, model_out());
        else n_pass++;
        tick();
        n_total++;
        if (obs !== 18'd0) $display("FAIL mvi_idle obs=%h exp=%h", obs, 18'd0);
        else n_pass++;
    endtask

    task automatic test_add();
        logic [17:0] want [3];
        want[0] = pack(8'd0, 1, 0, 3'd0, 0, 0, 0, 0, 1);
        want[1] = pack(8'd0, 0, 1, 3'd5, 0, 0, 0, 0, 1);
        want[2] = pack(8'b0000_0001, 0, 0, 3'd0, 0, 1, 0, 1, 1);
        ir_data = 9'b010_000_101; run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            run = 1'b0;
            n_total++;
            if (obs !== want[i] || obs !== model_out())
                $display("FAIL add_t%0d obs=%h exp=%h", i + 1, obs, want[i]);
            else n_pass++;
        end
        tick();
        n_total++;
        if (obs !== 18'd0) $display("FAIL add_idle obs=%h exp=%h", obs, 18'd0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        ir_data = 9'b011_010_001; run = 1'b1;
        tick();                         // T1 of sub
        tick();                         // T2 of sub
        n_total++;
        if (alu_sub !== 1'b1 || reg_num !== 3'd1 || obs !== model_out())
            $display("FAIL b2b_sub_t2 obs=%h exp=%h", obs, model_out());
        else n_pass++;
        ir_data = 9'b000_111_010;
        tick();                         // T3 of sub
        n_total++;
        if (done !== 1'b1 || enable !== 8'b0000_0100 || obs !== model_out())
            $display("FAIL b2b_sub_t3 obs=%h exp=%h", obs, model_out());
        else n_pass++;
        tick();                         // IDLE, run sampled here
        n_total++;
        if (obs !== 18'd0) $display("FAIL b2b_gap obs=%h exp=%h", obs, 18'd0);
        else n_pass++;
        tick();                         // T1 of mv r7,r2
        n_total++;
        if (obs !== pack(8'b1000_0000, 0, 0, 3'd2, 0, 0, 0, 1, 1) || obs !== model_out())
            $display("FAIL b2b_mv obs=%h exp=%h", obs, model_out());
        else n_pass++;
        // run held: mv completes every second cycle
        for (int i = 0; i < 6; i++) begin
            tick();
            n_total++;
            if (done !== ((i % 2) == 1) || obs !== model_out())
                $display("FAIL b2b_mv_rate obs=%h exp=%h", obs, model_out());
            else n_pass++;
        end
        run = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_run_ignored();
        logic [17:0] want [3];
        want[0] = pack(8'd0, 1, 0, 3'd3, 0, 0, 0, 0, 1);
        want[1] = pack(8'd0, 0, 1, 3'd3, 0, 0, 0, 0, 1);
        want[2] = pack(8'b0000_1000, 0, 0, 3'd0, 0, 1, 0, 1, 1);
        ir_data = 9'b010_011_011; run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (obs !== want[i] || obs !== model_out())
                $display("FAIL runign_t%0d obs=%h exp=%h", i + 1, obs, want[i]);
            else n_pass++;
            run = ~run;
            ir_data = 9'($urandom);
        end
        run = 1'b0;
        tick();
        n_total++;
        if (obs !== 18'd0) $display("FAIL runign_idle obs=%h exp=%h", obs, 18'd0);
        else n_pass++;
    endtask

    task automatic test_mvnz();
        logic [17:0] want_nz;
`ifdef INSTRUCTION_CONTROLLER_MVNZ_EN
        want_nz = pack(8'b0000_0010, 0, 0, 3'd6, 0, 0, 0, 1, 1);
`else
        want_nz = pack(8'd0, 0, 0, 3'd0, 0, 0, 0, 1, 1);
`endif
        ir_data = 9'b100_001_110; r_zero = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        n_total++;
        if (obs !== pack(8'd0, 0, 0, 3'd0, 0, 0, 0, 1, 1) || obs !== model_out())
            $display("FAIL mvnz_zero obs=%h exp=%h", obs, model_out());
        else n_pass++;
        tick();
        r_zero = 1'b0; run = 1'b1;
        tick();
        run = 1'b0;
        n_total++;
        if (obs !== want_nz || obs !== model_out())
            $display("FAIL mvnz_nonzero obs=%h exp=%h", obs, want_nz);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            run     = ($urandom_range(0, 3) != 0);
            ir_data = 9'($urandom);
            r_zero  = 1'($urandom);
            reset_n = ($urandom_range(0, 39) != 0);
            #1;
            n_total++;
            if (obs !== model_out()) $display("FAIL rand_pre obs=%h exp=%h cyc=%0d", obs, model_out(), i);
            else n_pass++;
            tick();
            n_total++;
            if (obs !== model_out() || !$onehot0(enable) || (sel_din && sel_r))
                $display("FAIL rand obs=%h exp=%h cyc=%0d", obs, model_out(), i);
            else n_pass++;
        end
        reset_n = 1'b1;
        run = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    initial begin
        test_reset();
        test_mvi();
        test_add();
        test_back_to_back();
        test_run_ignored();
        test_mvnz();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
